// File: rtl/wb_regfile.sv
// Writeback register file: 16 x DATA_WIDTH registers, Z/C/V flags and a retire counter.
// Optional build macro QSPA_WB_BYPASS_EN enables same-cycle write-through forwarding.
package qspa_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

module wb_regfile #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wb_stall,
  input  logic [qspa_pkg::DATA_WIDTH-1:0] wb_alu_result,
  input  logic [3:0]                     wb_rd_addr,
  input  logic                           wb_we,
  input  logic                           wb_flag_we,
  input  logic                           wb_flag_zero,
  input  logic                           wb_flag_carry,
  input  logic                           wb_flag_ovf,
  input  logic [3:0]                     rs1_addr,
  input  logic [3:0]                     rs2_addr,
  output logic [qspa_pkg::DATA_WIDTH-1:0] rs1_data,
  output logic [qspa_pkg::DATA_WIDTH-1:0] rs2_data,
  output logic                           flag_zero,
  output logic                           flag_carry,
  output logic                           flag_ovf,
  output logic [CNT_WIDTH-1:0]           retire_count
);

  logic [qspa_pkg::DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                            z_q, c_q, v_q;
  logic [CNT_WIDTH-1:0]            cnt_q;
  logic                            commit, reg_wr, flag_wr;
  logic [qspa_pkg::DATA_WIDTH-1:0] arr1, arr2;

  // A stalled cycle holds the EX/WB register, so it must not commit again.
  assign commit  = !rst && !wb_stall;
  assign reg_wr  = commit && wb_we && (wb_rd_addr != 4'd0);
  assign flag_wr = commit && wb_flag_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (reg_wr) regs[wb_rd_addr] <= wb_alu_result;
      if (flag_wr) begin
        z_q <= wb_flag_zero;
        c_q <= wb_flag_carry;
        v_q <= wb_flag_ovf;
      end
      // Writes to r0 are dropped but still retire; bubbles do not.
      if (commit && (wb_we || wb_flag_we)) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign arr1 = (rs1_addr == 4'd0) ? '0 : regs[rs1_addr];
  assign arr2 = (rs2_addr == 4'd0) ? '0 : regs[rs2_addr];

`ifdef QSPA_WB_BYPASS_EN
  assign rs1_data   = (reg_wr && rs1_addr == wb_rd_addr) ? wb_alu_result : arr1;
  assign rs2_data   = (reg_wr && rs2_addr == wb_rd_addr) ? wb_alu_result : arr2;
  assign flag_zero  = flag_wr ? wb_flag_zero  : z_q;
  assign flag_carry = flag_wr ? wb_flag_carry : c_q;
  assign flag_ovf   = flag_wr ? wb_flag_ovf   : v_q;
`else
  assign rs1_data   = arr1;
  assign rs2_data   = arr2;
  assign flag_zero  = z_q;
  assign flag_carry = c_q;
  assign flag_ovf   = v_q;
`endif

  assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile; a second instance with a 4-bit counter exercises wrap.
module tb_wb_regfile;
  localparam int DW = qspa_pkg::DATA_WIDTH;
`ifdef QSPA_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wb_stall, wb_we, wb_flag_we, fz, fc, fv;
  logic [DW-1:0] wb_alu_result;
  logic [3:0]    wb_rd_addr, rs1_addr, rs2_addr;
  logic [DW-1:0] rs1_data, rs2_data, n_rs1, n_rs2;
  logic          flag_zero, flag_carry, flag_ovf, n_z, n_c, n_v;
  logic [31:0]   retire_count;
  logic [3:0]    n_count;
  int            cyc = 0;
  int            errors = 0, checks = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] r1, r2;
    logic [2:0]  fl;
    logic [31:0] cnt;
  } exp_t;
  exp_t sbq[$];

  wb_regfile #(.NUM_REGS(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .wb_alu_result(wb_alu_result),
    .wb_rd_addr(wb_rd_addr), .wb_we(wb_we), .wb_flag_we(wb_flag_we),
    .wb_flag_zero(fz), .wb_flag_carry(fc), .wb_flag_ovf(fv),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
    .retire_count(retire_count)
  );

  wb_regfile #(.NUM_REGS(16), .CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .wb_alu_result(wb_alu_result),
    .wb_rd_addr(wb_rd_addr), .wb_we(wb_we), .wb_flag_we(wb_flag_we),
    .wb_flag_zero(fz), .wb_flag_carry(fc), .wb_flag_ovf(fv),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(n_rs1), .rs2_data(n_rs2),
    .flag_zero(n_z), .flag_carry(n_c), .flag_ovf(n_v),
    .retire_count(n_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) chk({e.name, "/sched"}, 32'(cyc), 32'(e.cyc));
      chk({e.name, "/rs1"}, 32'(rs1_data), e.r1);
      chk({e.name, "/rs2"}, 32'(rs2_data), e.r2);
      chk({e.name, "/flags"}, 32'({flag_zero, flag_carry, flag_ovf}), 32'(e.fl));
      chk({e.name, "/count"}, retire_count, e.cnt);
      chk({e.name, "/n_rs1"}, 32'(n_rs1), e.r1);
      chk({e.name, "/n_rs2"}, 32'(n_rs2), e.r2);
      chk({e.name, "/n_flags"}, 32'({n_z, n_c, n_v}), 32'(e.fl));
      chk({e.name, "/n_count"}, 32'(n_count), 32'(e.cnt[3:0]));
    end
  end

  task automatic drive(input logic s, input logic we, input logic [3:0] rd,
                       input logic [DW-1:0] res, input logic fwe, input logic [2:0] f,
                       input logic [3:0] a1, input logic [3:0] a2);
    wb_stall = s; wb_we = we; wb_rd_addr = rd; wb_alu_result = res;
    wb_flag_we = fwe; fz = f[2]; fc = f[1]; fv = f[0];
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 3'b000, a1, a2);
  endtask

  task automatic expect_now(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [2:0] fl, input logic [31:0] cnt);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.r1 = r1; e.r2 = r2; e.fl = fl; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(4'd0, 4'd0);
    tick; tick;
    rst = 1'b0;

    // Write r5, then reset over a competing write and flag update.
    drive(1'b0, 1'b1, 4'd5, 'hA5, 1'b0, 3'b000, 4'd0, 4'd0); tick;
    idle(4'd5, 4'd5); expect_now("r5_written", 'hA5, 'hA5, 3'b000, 1); tick;
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'd5, 'h77, 1'b1, 3'b111, 4'd5, 4'd5);
    expect_now("rst_c1", 'hA5, 'hA5, 3'b000, 1); tick;
    expect_now("rst_c2", 0, 0, 3'b000, 0); tick;
    rst = 1'b0;
    idle(4'd5, 4'd0); expect_now("after_rst", 0, 0, 3'b000, 0); tick;

    // Register write only; flag inputs are ignored.
    drive(1'b0, 1'b1, 4'd3, 'h1234, 1'b0, 3'b111, 4'd3, 4'd0);
    expect_now("t2_same", BYP ? 'h1234 : 0, 0, 3'b000, 0); tick;
    idle(4'd3, 4'd5); expect_now("t2_next", 'h1234, 0, 3'b000, 1); tick;

    // r0 write dropped but retired.
    drive(1'b0, 1'b1, 4'd0, 'hFFFF, 1'b0, 3'b000, 4'd0, 4'd0);
    expect_now("t3_same", 0, 0, 3'b000, 1); tick;
    idle(4'd0, 4'd3); expect_now("t3_next", 0, 'h1234, 3'b000, 2); tick;

    // Stall holds the op for three cycles; exactly one commit on release.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd7, 'h55, 1'b0, 3'b000, 4'd7, 4'd0);
      expect_now("t4_stall", 0, 0, 3'b000, 2); tick;
    end
    drive(1'b0, 1'b1, 4'd7, 'h55, 1'b0, 3'b000, 4'd7, 4'd0);
    expect_now("t4_rel", BYP ? 'h55 : 0, 0, 3'b000, 2); tick;
    idle(4'd7, 4'd3); expect_now("t4_next", 'h55, 'h1234, 3'b000, 3); tick;

    // Flag-only op, then a bubble that must not retire.
    drive(1'b0, 1'b0, 4'd3, 'hDEAD, 1'b1, 3'b101, 4'd3, 4'd7);
    expect_now("t5_same", 'h1234, 'h55, BYP ? 3'b101 : 3'b000, 3); tick;
    drive(1'b0, 1'b0, 4'd3, 'h0, 1'b0, 3'b000, 4'd3, 4'd7);
    expect_now("t5_next", 'h1234, 'h55, 3'b101, 4); tick;
    idle(4'd3, 4'd7); expect_now("t5_bubble", 'h1234, 'h55, 3'b101, 4); tick;

    // Read-during-write on both ports.
    drive(1'b0, 1'b1, 4'd9, 'h1111, 1'b0, 3'b000, 4'd0, 4'd0); tick;
    drive(1'b0, 1'b1, 4'd9, 'hBEEF, 1'b0, 3'b000, 4'd9, 4'd9);
    expect_now("t6_same", BYP ? 'hBEEF : 'h1111, BYP ? 'hBEEF : 'h1111, 3'b101, 5); tick;
    idle(4'd9, 4'd9); expect_now("t6_next", 'hBEEF, 'hBEEF, 3'b101, 6); tick;

    // Drive the 4-bit counter to all-ones, then one more commit wraps it to 0.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 4'd10, DW'(i), 1'b0, 3'b000, 4'd0, 4'd0); tick;
    end
    idle(4'd10, 4'd0); expect_now("wrap_ones", 'h8, 0, 3'b101, 15); tick;
    drive(1'b0, 1'b0, 4'd0, 'h0, 1'b1, 3'b010, 4'd0, 4'd0); tick;
    idle(4'd10, 4'd9); expect_now("wrap_zero", 'h8, 'hBEEF, 3'b010, 16); tick;

    tick; tick;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
